// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder controller.
// Holds the controller state encoding, the slice-index width helper and the
// operand/slice width compatibility check used at elaboration.
package cla_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index counter: clog2(n), never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when the operand width is a whole number of slices.
  function automatic bit slices_divide(input int unsigned data_w, input int unsigned slice_w);
    return (slice_w != 0) && ((data_w % slice_w) == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE_W-bit carry-lookahead adder slice.
// Ports:
//   a, b   : slice operands
//   c_in   : carry into bit 0
//   s      : slice sum
//   c_out  : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (signed-overflow detection)
module cla_slice #(
  parameter int unsigned SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] s,
  output logic               c_out,
  output logic               c_msb
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W:0]   w_c;
  logic               w_term;

  // Per-bit propagate / generate cells.
  assign w_p = a ^ b;
  assign w_g = a & b;

  // Flat lookahead: c[i] = OR_j (g[j] & p[j+1..i-1]) | (c_in & p[0..i-1]).
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = c_in;
    for (int i = 1; i <= int'(SLICE_W); i++) begin
      w_term = c_in;
      for (int k = 0; k < i; k++) begin
        w_term = w_term & w_p[k];
      end
      w_c[i] = w_term;
      for (int j = 0; j < i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k < i; k++) begin
          w_term = w_term & w_p[k];
        end
        w_c[i] = w_c[i] | w_term;
      end
    end
  end

  assign s     = w_p ^ w_c[SLICE_W-1:0];
  assign c_out = w_c[SLICE_W];
  assign c_msb = w_c[SLICE_W-1];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle add/subtract: one shared CLA slice is applied LSB slice first,
// one slice per clock, with the carry registered between slices.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   busy                : operation in progress or result pending
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;
  localparam int unsigned IDX_W      = idx_width(NUM_SLICES);

  if (!slices_divide(DATA_W, SLICE_W)) begin : g_width_check
    $error("cla_seq_adder_ctrl: DATA_W must be a multiple of SLICE_W");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_step;
  logic                w_last;

  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_carry;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_sum;
  logic                r_cout;
  logic                r_ovf;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic [SLICE_W-1:0]  w_sl_a;
  logic [SLICE_W-1:0]  w_sl_b;
  logic [SLICE_W-1:0]  w_sl_s;
  logic                w_sl_cout;
  logic                w_sl_cmsb;

  // Current slice of the captured operands.
  assign w_sl_a = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_sl_b = r_b[r_idx*SLICE_W +: SLICE_W];
  assign w_last = (r_idx == IDX_W'(NUM_SLICES - 1));

  cla_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a     (w_sl_a),
    .b     (w_sl_b),
    .c_in  (r_carry),
    .s     (w_sl_s),
    .c_out (w_sl_cout),
    .c_msb (w_sl_cmsb)
  );

  // State register plus handshake/status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture and slice-by-slice accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      // Subtract as a + ~b + 1.
      r_b     <= sub ? ~b : b;
      r_carry <= sub | cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (w_step) begin
      r_sum[r_idx*SLICE_W +: SLICE_W] <= w_sl_s;
      r_carry <= w_sl_cout;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_sl_cout;
        r_ovf  <= w_sl_cmsb ^ w_sl_cout;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl (DATA_W=32, SLICE_W=8).
module tb_cla_seq_adder_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned NS = DW / SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          cout;
  logic          ovf;
  logic          busy;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(
    .DATA_W  (DW),
    .SLICE_W (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          ovf;
    logic          cout;
    logic [DW-1:0] sum;
  } res_t;

  // Reference result from plain integer arithmetic.
  function automatic res_t ref_op(input logic [DW-1:0] fa, input logic [DW-1:0] fb,
                                  input logic fc, input logic fs);
    res_t        r;
    logic [DW:0] u;
    logic [DW:0] sx;
    if (fs) begin
      u      = {1'b0, fa} - {1'b0, fb};
      r.sum  = u[DW-1:0];
      r.cout = (fa >= fb);
      sx     = {fa[DW-1], fa} - {fb[DW-1], fb};
    end else begin
      u      = {1'b0, fa} + {1'b0, fb} + (DW+1)'(fc);
      r.sum  = u[DW-1:0];
      r.cout = u[DW];
      sx     = {fa[DW-1], fa} + {fb[DW-1], fb} + (DW+1)'(fc);
    end
    r.ovf = sx[DW] ^ sx[DW-1];
    return r;
  endfunction

  // Transaction-level model: 0 idle, 1 computing (m_cnt edges left), 2 result held.
  int   m_ph;
  int   m_cnt;
  res_t m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  <= 0;
      m_cnt <= 0;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
          m_ph  <= 1;
          m_cnt <= int'(NS);
          m_exp <= ref_op(a, b, cin, sub);
        end
        1: if (m_cnt == 1) m_ph <= 2;
           else m_cnt <= m_cnt - 1;
        default: if (out_ready) m_ph <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
    end else begin
      chk("in_ready", 64'(in_ready), 64'(m_ph == 0));
      chk("busy", 64'(busy), 64'(m_ph != 0));
      chk("out_valid", 64'(out_valid), 64'(m_ph == 2));
      if (m_ph == 2) begin
        chk("sum", 64'(sum), 64'(m_exp.sum));
        chk("cout", 64'(cout), 64'(m_exp.cout));
        chk("ovf", 64'(ovf), 64'(m_exp.ovf));
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic send(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                      input logic tc, input logic ts);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'(1));
    a = ta; b = tb_v; cin = tc; sub = ts;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_wait", 64'(out_valid), 64'(1));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                          input logic tc, input logic ts,
                          input logic [DW-1:0] es, input logic ec, input logic eo);
    int lat;
    send(ta, tb_v, tc, ts);
    wait_done(lat);
    chk({nm, "_latency"}, 64'(lat), 64'(4));
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
    chk({nm, "_model"}, 64'(m_exp), 64'({eo, ec, es}));
    pop();
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("init_in_ready", 64'(in_ready), 64'(1));
    chk("init_out_valid", 64'(out_valid), 64'(0));
    chk("init_sum", 64'(sum), 64'(0));

    directed("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    directed("add_carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("add_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("add_neg_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    directed("add_cin", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    // Backpressure: result held, new operands refused.
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    wait_done(lat);
    repeat (10) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_sum", 64'(sum), 64'(32'h2345_678A));
    chk("bp_cout", 64'(cout), 64'(0));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    pop();
    directed("after_bp", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

    // Reset in the middle of RUN.
    send(32'h0101_0101, 32'h0000_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_run_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_sum", 64'(sum), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    directed("post_rst_1p1", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);

    // Randomised traffic, checked every cycle by the monitor.
    for (int i = 0; i < 150; i++) begin
      send(pick(), pick(), 1'($urandom), 1'($urandom));
      wait_done(lat);
      chk("rand_latency", 64'(lat), 64'(NS));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      pop();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
